// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto a single shared memory request channel.
// Contention policy: define ARB_RR_EN for round-robin, otherwise D-cache always wins.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_req_valid,
  input  logic              ic_req_wr,
  input  logic [DATA_W-1:0] ic_wr_data,
  output logic [DATA_W-1:0] ic_req_data,
  output logic              ic_req_ready,
  // D-cache side
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_valid,
  input  logic              dc_req_wr,
  input  logic [DATA_W-1:0] dc_wr_data,
  output logic [DATA_W-1:0] dc_req_data,
  output logic              dc_req_ready,
  // shared memory side
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_req_valid,
  output logic              mem_req_wr,
  input  logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t state;
  logic   grant_d;

`ifdef ARB_RR_EN
  // Set when the D-cache held the most recent grant; resets to "I" so D wins first contention.
  logic last_d;

  always_comb begin
    grant_d = dc_req_valid;
    if (ic_req_valid && dc_req_valid) begin
      grant_d = ~last_d;
    end
  end
`else
  always_comb begin
    grant_d = dc_req_valid;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      mem_req_valid <= 1'b0;
      mem_req_wr    <= 1'b0;
      mem_req_addr  <= '0;
      mem_wr_data   <= '0;
      ic_req_ready  <= 1'b0;
      dc_req_ready  <= 1'b0;
      ic_req_data   <= '0;
      dc_req_data   <= '0;
`ifdef ARB_RR_EN
      last_d        <= 1'b0;
`endif
    end else begin
      ic_req_ready <= 1'b0;
      dc_req_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ic_req_valid || dc_req_valid) begin
            mem_req_valid <= 1'b1;
`ifdef ARB_RR_EN
            last_d        <= grant_d;
`endif
            if (grant_d) begin
              mem_req_addr <= dc_req_addr;
              mem_req_wr   <= dc_req_wr;
              mem_wr_data  <= dc_wr_data;
              state        <= BUSY_D;
            end else begin
              mem_req_addr <= ic_req_addr;
              mem_req_wr   <= ic_req_wr;
              mem_wr_data  <= ic_wr_data;
              state        <= BUSY_I;
            end
          end
        end
        BUSY_I: begin
          if (mem_req_ready) begin
            if (!mem_req_wr) begin
              ic_req_data <= mem_req_data;
            end
            mem_req_valid <= 1'b0;
            ic_req_ready  <= 1'b1;
            state         <= DONE_I;
          end
        end
        BUSY_D: begin
          if (mem_req_ready) begin
            if (!mem_req_wr) begin
              dc_req_data <= mem_req_data;
            end
            mem_req_valid <= 1'b0;
            dc_req_ready  <= 1'b1;
            state         <= DONE_D;
          end
        end
        DONE_I, DONE_D: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; contention expectations follow ARB_RR_EN.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ic_req_addr;
  logic          ic_req_valid;
  logic          ic_req_wr;
  logic [DW-1:0] ic_wr_data;
  logic [DW-1:0] ic_req_data;
  logic          ic_req_ready;
  logic [AW-1:0] dc_req_addr;
  logic          dc_req_valid;
  logic          dc_req_wr;
  logic [DW-1:0] dc_wr_data;
  logic [DW-1:0] dc_req_data;
  logic          dc_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_req_valid;
  logic          mem_req_wr;
  logic [DW-1:0] mem_req_data;
  logic          mem_req_ready;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ic_req_addr  (ic_req_addr),
    .ic_req_valid (ic_req_valid),
    .ic_req_wr    (ic_req_wr),
    .ic_wr_data   (ic_wr_data),
    .ic_req_data  (ic_req_data),
    .ic_req_ready (ic_req_ready),
    .dc_req_addr  (dc_req_addr),
    .dc_req_valid (dc_req_valid),
    .dc_req_wr    (dc_req_wr),
    .dc_wr_data   (dc_wr_data),
    .dc_req_data  (dc_req_data),
    .dc_req_ready (dc_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_wr   (mem_req_wr),
    .mem_req_data (mem_req_data),
    .mem_req_ready(mem_req_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Both readies must never be high together.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_tests++;
      assert (!(ic_req_ready && dc_req_ready))
      else begin
        n_fail++;
        $error("FAIL both_ready: observed ic=%0b dc=%0b expected not both 1", ic_req_ready, dc_req_ready);
      end
    end
  end

  // Returns at the negedge where a ready pulse is seen; got_d=1 means D-cache.
  task automatic wait_ready(input string tag, output logic got_d);
    logic seen;
    seen  = 1'b0;
    got_d = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (ic_req_ready || dc_req_ready) begin
        seen  = 1'b1;
        got_d = dc_req_ready;
      end
    end
    chk({tag, "_timeout"}, {63'd0, seen}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  logic          g;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic          hold_wr;

  initial begin
    rst = 1'b0;
    ic_req_addr = '0; ic_req_valid = 1'b0; ic_req_wr = 1'b0; ic_wr_data = '0;
    dc_req_addr = '0; dc_req_valid = 1'b0; dc_req_wr = 1'b0; dc_wr_data = '0;
    mem_req_data = '0; mem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_wr",    mem_req_wr, 0);
    chk("rst_mem_addr",  mem_req_addr, 0);
    chk("rst_mem_wdata", mem_wr_data, 0);
    chk("rst_ic_ready",  ic_req_ready, 0);
    chk("rst_dc_ready",  dc_req_ready, 0);
    chk("rst_ic_data",   ic_req_data, 0);
    chk("rst_dc_data",   dc_req_data, 0);
    rst = 1'b1;

    // Single I read, accepted in the first IDLE cycle after reset (cycle 0).
    ic_req_addr = 32'h0000_0040; ic_req_valid = 1'b1;
    @(negedge clk); // cycle 1
    chk("i_rd_c1_valid", mem_req_valid, 1);
    chk("i_rd_c1_addr",  mem_req_addr, 32'h40);
    chk("i_rd_c1_wr",    mem_req_wr, 0);
    chk("i_rd_c1_ready", ic_req_ready, 0);
    @(negedge clk); // cycle 2
    chk("i_rd_c2_valid", mem_req_valid, 1);
    @(negedge clk); // cycle 3
    chk("i_rd_c3_valid", mem_req_valid, 1);
    chk("i_rd_c3_ready", ic_req_ready, 0);
    mem_req_ready = 1'b1; mem_req_data = 32'hDEAD_BEEF;
    @(negedge clk); // cycle 4
    chk("i_rd_c4_ready", ic_req_ready, 1);
    chk("i_rd_c4_data",  ic_req_data, 32'hDEAD_BEEF);
    chk("i_rd_c4_valid", mem_req_valid, 0);
    ic_req_valid = 1'b0; mem_req_ready = 1'b0; mem_req_data = '0;
    @(negedge clk); // cycle 5, IDLE
    chk("i_rd_c5_ready", ic_req_ready, 0);
    chk("i_rd_c5_hold",  ic_req_data, 32'hDEAD_BEEF);

    // D write
    dc_req_addr = 32'h0000_0100; dc_req_wr = 1'b1; dc_wr_data = 32'h1234_5678; dc_req_valid = 1'b1;
    @(negedge clk);
    chk("d_wr_valid", mem_req_valid, 1);
    chk("d_wr_wr",    mem_req_wr, 1);
    chk("d_wr_addr",  mem_req_addr, 32'h100);
    chk("d_wr_wdata", mem_wr_data, 32'h1234_5678);
    mem_req_ready = 1'b1; mem_req_data = 32'hFFFF_0000;
    @(negedge clk);
    chk("d_wr_ready", dc_req_ready, 1);
    chk("d_wr_data_unchanged", dc_req_data, 0);
    chk("d_wr_valid_drop", mem_req_valid, 0);
    dc_req_valid = 1'b0; dc_req_wr = 1'b0;
    @(negedge clk); // IDLE with mem_req_ready still 1: must be ignored
    chk("d_wr_pulse_end", dc_req_ready, 0);
    @(negedge clk);
    chk("idle_ign_valid", mem_req_valid, 0);
    chk("idle_ign_ic",    ic_req_ready, 0);
    chk("idle_ign_dc",    dc_req_ready, 0);
    mem_req_ready = 1'b0;

    // Mem stall on a D read; I request raised while D is busy must wait.
    dc_req_addr = 32'h0000_ABC0; dc_wr_data = 32'h5555_AAAA; dc_req_valid = 1'b1;
    @(negedge clk);
    chk("stall_valid0", mem_req_valid, 1);
    chk("stall_addr0",  mem_req_addr, 32'hABC0);
    hold_addr = mem_req_addr; hold_wdata = mem_wr_data; hold_wr = mem_req_wr;
    ic_req_addr = 32'h0000_0080; ic_req_valid = 1'b1;
    dc_req_addr = 32'hFFFF_FFF0; dc_wr_data = 32'h0; dc_req_wr = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("stall_addr",  mem_req_addr, 32'hABC0);
      chk("stall_wdata", mem_wr_data, 32'h5555_AAAA);
      chk("stall_wr",    mem_req_wr, 0);
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_dc_rdy", dc_req_ready, 0);
      chk("stall_ic_rdy", ic_req_ready, 0);
    end
    mem_req_ready = 1'b1; mem_req_data = 32'h0BAD_F00D;
    @(negedge clk);
    chk("stall_done_rdy", dc_req_ready, 1);
    chk("stall_done_data", dc_req_data, 32'h0BAD_F00D);
    dc_req_valid = 1'b0; dc_req_wr = 1'b0; mem_req_ready = 1'b0;
    @(negedge clk); // IDLE samples the waiting I request
    chk("wait_i_idle_valid", mem_req_valid, 0);
    @(negedge clk);
    chk("wait_i_valid", mem_req_valid, 1);
    chk("wait_i_addr",  mem_req_addr, 32'h80);
    mem_req_ready = 1'b1; mem_req_data = 32'h1111_2222;
    @(negedge clk);
    chk("wait_i_ready", ic_req_ready, 1);
    chk("wait_i_data",  ic_req_data, 32'h1111_2222);
    ic_req_valid = 1'b0; mem_req_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of BUSY_I.
    ic_req_addr = 32'h0000_0200; ic_req_valid = 1'b1;
    @(negedge clk);
    chk("rbusy_valid", mem_req_valid, 1);
    #2;
    rst = 1'b0; ic_req_valid = 1'b0;
    #1;
    chk("rbusy_async_valid", mem_req_valid, 0);
    chk("rbusy_async_data",  ic_req_data, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rbusy_no_ready", ic_req_ready, 0);
      chk("rbusy_no_valid", mem_req_valid, 0);
    end
    ic_req_addr = 32'h0000_0300; ic_req_valid = 1'b1;
    @(negedge clk);
    chk("rpost_valid", mem_req_valid, 1);
    chk("rpost_addr",  mem_req_addr, 32'h300);
    mem_req_ready = 1'b1; mem_req_data = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rpost_ready", ic_req_ready, 1);
    chk("rpost_data",  ic_req_data, 32'hCAFE_F00D);
    ic_req_valid = 1'b0; mem_req_ready = 1'b0;
    @(negedge clk);

    // Contention: both requesters valid, memory always ready.
    ic_req_addr = 32'h0000_1000; dc_req_addr = 32'h0000_2000;
    ic_req_wr = 1'b0; dc_req_wr = 1'b0;
    mem_req_ready = 1'b1; mem_req_data = 32'h7777_0000;
    ic_req_valid = 1'b1; dc_req_valid = 1'b1;
`ifdef ARB_RR_EN
    // last grant before this point was I, so order is D, I, D, I
    for (int t = 0; t < 4; t++) begin
      wait_ready("rr_wait", g);
      chk("rr_grant", {63'd0, g}, (t % 2 == 0) ? 64'd1 : 64'd0);
    end
`else
    for (int t = 0; t < 3; t++) begin
      wait_ready("fix_wait", g);
      chk("fix_grant_d", {63'd0, g}, 64'd1);
    end
    dc_req_valid = 1'b0;
    wait_ready("fix_wait_i", g);
    chk("fix_grant_i", {63'd0, g}, 64'd0);
`endif
    ic_req_valid = 1'b0; dc_req_valid = 1'b0; mem_req_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all data ports.
REQ-003 SHALL have ports clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have ports rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have ports ic_req_addr, ic_req_valid, ic_req_wr, ic_wr_data, input, ADDR_W/1/1/DATA_W, I-cache request.
REQ-006 SHALL have ports ic_req_data, ic_req_ready, output, DATA_W/1, I-cache response.
REQ-007 SHALL have ports dc_req_addr, dc_req_valid, dc_req_wr, dc_wr_data, input, ADDR_W/1/1/DATA_W, D-cache request.
REQ-008 SHALL have ports dc_req_data, dc_req_ready, output, DATA_W/1, D-cache response.
REQ-009 SHALL have ports mem_req_addr, mem_wr_data, mem_req_valid, mem_req_wr, output, ADDR_W/DATA_W/1/1, shared memory request.
REQ-010 SHALL have ports mem_req_data, mem_req_ready, input, DATA_W/1, memory response.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
REQ-012 IDLE: SHALL sample ic_req_valid/dc_req_valid; if any is high, SHALL register the winner's addr, wr, wr_data into mem_req_* and go to BUSY_x; else stay IDLE.
REQ-013 Only one requester high: SHALL grant that requester.
REQ-014 Both high in the same IDLE cycle: SHALL grant per REQ-030/031.
REQ-015 BUSY_x: mem_req_valid SHALL be 1 and mem_req_addr/wr/wr_data SHALL stay constant until mem_req_ready is sampled 1.
REQ-016 BUSY_x with mem_req_ready=1: SHALL register mem_req_data into x_req_data (reads only; writes leave x_req_data unchanged), drop mem_req_valid, go to DONE_x.
REQ-017 DONE_x: x_req_ready SHALL be 1 for exactly this one cycle; next state SHALL be IDLE.
REQ-018 x_req_data SHALL hold its value after DONE_x until the next read completion for that side.
REQ-019 Latency: request in IDLE at cycle 0 -> mem_req_valid=1 at cycle 1; mem_req_ready=1 at cycle k>=1 -> x_req_ready=1 at cycle k+1.
REQ-020 The non-granted requester SHALL see ready=0 and SHALL be serviced no earlier than the IDLE cycle following the current DONE.
REQ-021 mem_req_ready SHALL be ignored in IDLE and DONE_x.
REQ-022 ic_req_ready and dc_req_ready SHALL never be 1 in the same cycle.
REQ-023 Requesters SHALL hold valid and request fields until ready; the arbiter SHALL NOT re-sample request fields during BUSY_x.

Reset
REQ-024 rst=0 SHALL force state IDLE immediately, independent of clk.
REQ-025 Reset values SHALL be: mem_req_valid 0, mem_req_wr 0, mem_req_addr 0, mem_wr_data 0, ic_req_ready 0, dc_req_ready 0, ic_req_data 0, dc_req_data 0.
REQ-026 Reset during BUSY_x SHALL abandon the transaction; no ready pulse SHALL follow for it.
REQ-027 The round-robin last-grant register, when present, SHALL reset to I, so D wins the first contention.
REQ-028 First request SHALL be accepted in the first IDLE cycle after rst rises.

Configuration
REQ-029 Macro ARB_RR_EN SHALL select the contention policy.
REQ-030 ARB_RR_EN defined: on contention, SHALL grant the side not granted last; the last-grant register SHALL update on every grant.
REQ-031 ARB_RR_EN undefined: on contention, SHALL always grant D-cache; no last-grant register SHALL exist.

Verification
REQ-032 Bench SHALL cover single I read: ic addr 0x0000_0040, valid; mem ready at cycle 3 with data 0xDEAD_BEEF -> mem_req_valid cycles 1-3, ic_req_ready=1 at cycle 4, ic_req_data=0xDEAD_BEEF.
REQ-033 Bench SHALL cover D write: dc addr 0x0000_0100, wr=1, data 0x1234_5678 -> mem_req_wr=1, mem_wr_data=0x1234_5678, dc_req_ready pulse one cycle after mem ready, dc_req_data unchanged.
REQ-034 Bench SHALL cover contention with ARB_RR_EN: both valid continuously for 4 transactions -> grant order D, I, D, I; never both readies high.
REQ-035 Bench SHALL cover contention without ARB_RR_EN: both valid for 3 transactions -> D, D, D while dc valid stays high; I served after dc valid drops.
REQ-036 Bench SHALL cover reset mid-BUSY: rst=0 mid-cycle in BUSY_I -> mem_req_valid=0 before next clk edge; no ic_req_ready pulse; next request serviced normally.
REQ-037 Bench SHALL cover mem stall: mem_req_ready held 0 for 20 cycles -> mem_req_addr/wr/wr_data stable throughout, no ready pulse until mem_req_ready=1.
